// File: rtl/filtro_biquad_multibanda.sv
// Time-multiplexed direct-form-II biquad serving NumBandas channels through one shared MAC.
// Optional macro FILTRO_REDONDEO_EN: round products half toward +inf instead of floor truncation.
module filtro_biquad_multibanda #(
  parameter int Width     = 22,
  parameter int Presicion = 14,
  parameter int NumBandas = 3,
  parameter int AccGuard  = 4,
  localparam int BW  = (NumBandas > 1) ? $clog2(NumBandas) : 1,
  localparam int CAW = (NumBandas * 5 > 1) ? $clog2(NumBandas * 5) : 1
) (
  input  logic                    clk150kHz,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BW-1:0]           banda,
  input  logic signed [Width-1:0] uk,
  input  logic                    coef_we,
  input  logic [CAW-1:0]          coef_addr,
  input  logic signed [Width-1:0] coef_data,
  input  logic                    clr_estado,
  output logic signed [Width-1:0] yk,
  output logic                    out_valid,
  output logic                    sat_flag
);

  localparam int ACCW = Width + AccGuard;
  localparam logic signed [ACCW-1:0]  MAXV = {{(AccGuard + 1){1'b0}}, {(Width - 1){1'b1}}};
  localparam logic signed [ACCW-1:0]  MINV = {{(AccGuard + 1){1'b1}}, {(Width - 1){1'b0}}};
  localparam logic signed [Width-1:0] MAXW = {1'b0, {(Width - 1){1'b1}}};
  localparam logic signed [Width-1:0] MINW = {1'b1, {(Width - 1){1'b0}}};
  localparam logic signed [Width-1:0] ONE  = Width'(1) << Presicion;
`ifdef FILTRO_REDONDEO_EN
  localparam logic signed [2*Width-1:0] RND = (2 * Width)'(1) << (Presicion - 1);
`endif

  typedef enum logic [2:0] {IDLE, MA1, MA2, FK, MB0, MB1, MB2, DONE} state_t;

  state_t                  state;
  logic signed [Width-1:0] coef [NumBandas][5];
  logic signed [Width-1:0] w1 [NumBandas];
  logic signed [Width-1:0] w2 [NumBandas];
  logic signed [Width-1:0] uk_q, fk_q;
  logic [BW-1:0]           banda_q;
  logic                    bypass_q;
  logic signed [ACCW-1:0]  acc;

  logic [BW-1:0]             ch;
  logic signed [Width-1:0]   mul_a, mul_b;
  logic signed [2*Width-1:0] prod, shifted;
  logic signed [ACCW-1:0]    term, uk_ext, acc_next;

  function automatic logic signed [Width-1:0] sat(input logic signed [ACCW-1:0] v);
    if (v > MAXV) return MAXW;
    if (v < MINV) return MINW;
    return v[Width-1:0];
  endfunction

  function automatic logic clamps(input logic signed [ACCW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  assign in_ready = (state == IDLE) && !clr_estado;
  // Bypass requests never touch a real channel, so point them at channel 0 to keep indexing in range.
  assign ch       = bypass_q ? '0 : banda_q;
  assign uk_ext   = {{AccGuard{uk_q[Width-1]}}, uk_q};

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MA1:     begin mul_a = coef[ch][3]; mul_b = w1[ch]; end
      MA2:     begin mul_a = coef[ch][4]; mul_b = w2[ch]; end
      MB0:     begin mul_a = coef[ch][0]; mul_b = fk_q;   end
      MB1:     begin mul_a = coef[ch][1]; mul_b = w1[ch]; end
      MB2:     begin mul_a = coef[ch][2]; mul_b = w2[ch]; end
      default: ;
    endcase
`ifdef FILTRO_REDONDEO_EN
    prod = mul_a * mul_b + RND;
`else
    prod = mul_a * mul_b;
`endif
    shifted  = prod >>> Presicion;
    term     = shifted[ACCW-1:0];
    acc_next = (state == MA1) ? uk_ext + term : acc + term;
  end

  // Sequencer, coefficient bank and per-channel state share one register block.
  always_ff @(posedge clk150kHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      uk_q      <= '0;
      fk_q      <= '0;
      banda_q   <= '0;
      bypass_q  <= 1'b0;
      yk        <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int b = 0; b < NumBandas; b++) begin
        w1[b]      <= '0;
        w2[b]      <= '0;
        coef[b][0] <= ONE;
        for (int k = 1; k < 5; k++) coef[b][k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (coef_we) begin
        for (int b = 0; b < NumBandas; b++)
          for (int k = 0; k < 5; k++)
            if (coef_addr == CAW'(b * 5 + k)) coef[b][k] <= coef_data;
      end
      case (state)
        IDLE: begin
          if (clr_estado) begin
            sat_flag <= 1'b0;
            for (int b = 0; b < NumBandas; b++) begin
              w1[b] <= '0;
              w2[b] <= '0;
            end
          end else if (in_valid) begin
            uk_q     <= uk;
            banda_q  <= banda;
            bypass_q <= (int'(banda) >= NumBandas);
            state    <= MA1;
          end
        end
        MA1: begin acc <= acc_next; state <= MA2; end
        MA2: begin acc <= acc_next; state <= FK;  end
        FK: begin
          fk_q <= sat(acc);
          acc  <= '0;
          if (!bypass_q && clamps(acc)) sat_flag <= 1'b1;
          state <= MB0;
        end
        MB0: begin acc <= acc_next; state <= MB1;  end
        MB1: begin acc <= acc_next; state <= MB2;  end
        MB2: begin acc <= acc_next; state <= DONE; end
        DONE: begin
          if (bypass_q) begin
            yk <= uk_q;
          end else begin
            yk <= sat(acc);
            if (clamps(acc)) sat_flag <= 1'b1;
            w2[ch] <= w1[ch];
            w1[ch] <= fk_q;
          end
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_biquad_multibanda.sv
// Directed and randomized checks of filtro_biquad_multibanda against an arithmetic reference model.
module tb_filtro_biquad_multibanda;
  localparam int Width     = 22;
  localparam int Presicion = 14;
  localparam int NumBandas = 3;
  localparam int AccGuard  = 4;
  localparam int BW  = (NumBandas > 1) ? $clog2(NumBandas) : 1;
  localparam int CAW = (NumBandas * 5 > 1) ? $clog2(NumBandas * 5) : 1;
  localparam longint SMAX = (longint'(1) <<< (Width - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (Width - 1));

  logic clk150kHz = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic coef_we = 1'b0;
  logic clr_estado = 1'b0;
  logic [BW-1:0] banda = '0;
  logic signed [Width-1:0] uk = '0;
  logic [CAW-1:0] coef_addr = '0;
  logic signed [Width-1:0] coef_data = '0;
  logic in_ready, out_valid, sat_flag;
  logic signed [Width-1:0] yk;

  int compared = 0;
  int mismatched = 0;

  longint mcoef [NumBandas][5];
  longint mw1 [NumBandas];
  longint mw2 [NumBandas];
  bit     msat;
  longint expYk;

  filtro_biquad_multibanda #(
    .Width(Width), .Presicion(Presicion), .NumBandas(NumBandas), .AccGuard(AccGuard)
  ) dut (
    .clk150kHz(clk150kHz), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .banda(banda), .uk(uk), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clr_estado(clr_estado), .yk(yk), .out_valid(out_valid), .sat_flag(sat_flag)
  );

  always #5 clk150kHz = ~clk150kHz;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint mulq(input longint c, input longint w);
    longint p;
    p = c * w;
`ifdef FILTRO_REDONDEO_EN
    p = p + (longint'(1) <<< (Presicion - 1));
`endif
    return p >>> Presicion;
  endfunction

  function automatic longint clampW(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  task automatic modelReset();
    for (int b = 0; b < NumBandas; b++) begin
      mcoef[b][0] = longint'(1) <<< Presicion;
      for (int k = 1; k < 5; k++) mcoef[b][k] = 0;
      mw1[b] = 0;
      mw2[b] = 0;
    end
    msat = 1'b0;
  endtask

  // Reference: fk = sat(u + a1*w1 + a2*w2), y = sat(b0*fk + b1*w1 + b2*w2), then shift history.
  task automatic modelStep(input int b, input longint u, output longint y);
    longint f, acc;
    if (b >= NumBandas) begin
      y = u;
      return;
    end
    f = u + mulq(mcoef[b][3], mw1[b]) + mulq(mcoef[b][4], mw2[b]);
    if (f != clampW(f)) msat = 1'b1;
    f = clampW(f);
    acc = mulq(mcoef[b][0], f) + mulq(mcoef[b][1], mw1[b]) + mulq(mcoef[b][2], mw2[b]);
    if (acc != clampW(acc)) msat = 1'b1;
    y = clampW(acc);
    mw2[b] = mw1[b];
    mw1[b] = f;
  endtask

  task automatic writeCoef(input int addr, input longint data);
    @(negedge clk150kHz);
    coef_we   = 1'b1;
    coef_addr = CAW'(addr);
    coef_data = Width'(data);
    @(posedge clk150kHz);
    #1 coef_we = 1'b0;
    if (addr < NumBandas * 5) mcoef[addr / 5][addr % 5] = data;
  endtask

  task automatic clearState();
    @(negedge clk150kHz);
    clr_estado = 1'b1;
    @(posedge clk150kHz);
    #1 clr_estado = 1'b0;
    for (int b = 0; b < NumBandas; b++) begin
      mw1[b] = 0;
      mw2[b] = 0;
    end
    msat = 1'b0;
  endtask

  task automatic applyStimulus(input int b, input longint u, input string tag);
    int waitc;
    int lat;
    waitc = 0;
    lat = -1;
    @(negedge clk150kHz);
    while (in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk150kHz);
      waitc++;
    end
    checkOutput({tag, "_ready"}, in_ready, 1);
    banda    = BW'(b);
    uk       = Width'(u);
    in_valid = 1'b1;
    @(posedge clk150kHz);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk150kHz);
      #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    modelStep(b, u, expYk);
    checkOutput({tag, "_lat"}, lat, 7);
    checkOutput({tag, "_yk"}, yk, expYk);
    checkOutput({tag, "_sat"}, sat_flag, msat);
  endtask

  initial begin
    int accepts;
    int ovCount;
    longint u;
    int b;

    modelReset();
    repeat (3) @(posedge clk150kHz);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_yk", yk, 0);
    checkOutput("rst_sat", sat_flag, 0);
    @(negedge clk150kHz);
    reset = 1'b1;

    applyStimulus(0, 1000, "identity");
    checkOutput("identity_const", yk, 1000);

    writeCoef(5, 8192);
    writeCoef(8, 8192);
    applyStimulus(1, 16384, "imp0");
    checkOutput("imp0_const", yk, 8192);
    applyStimulus(1, 0, "imp1");
    checkOutput("imp1_const", yk, 4096);
    applyStimulus(1, 0, "imp2");
    checkOutput("imp2_const", yk, 2048);

    clearState();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 500, "inter_b0");
      checkOutput("inter_b0_const", yk, 500);
      applyStimulus(1, (i == 0) ? 16384 : 0, "inter_b1");
      checkOutput("inter_b1_const", yk, 8192 >> i);
    end

    writeCoef(10, 32768);
    applyStimulus(2, 1500000, "sat_pos");
    checkOutput("sat_pos_const", yk, 2097151);
    checkOutput("sat_pos_flag", sat_flag, 1);
    applyStimulus(2, -1500000, "sat_neg");
    checkOutput("sat_neg_const", yk, -2097152);
    clearState();
    #1 checkOutput("sat_cleared", sat_flag, 0);

    @(negedge clk150kHz);
    clr_estado = 1'b1;
    in_valid   = 1'b1;
    banda      = '0;
    uk         = 77;
    #1 checkOutput("clr_blocks_ready", in_ready, 0);
    @(posedge clk150kHz);
    #1;
    clr_estado = 1'b0;
    in_valid   = 1'b0;
    ovCount = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk150kHz);
      #1 if (out_valid === 1'b1) ovCount++;
    end
    checkOutput("clr_no_accept", ovCount, 0);

    @(negedge clk150kHz);
    banda    = '0;
    uk       = '0;
    in_valid = 1'b1;
    accepts  = 0;
    for (int k = 0; k < 40; k++) begin
      if (in_ready === 1'b1 && in_valid === 1'b1) accepts++;
      @(negedge clk150kHz);
    end
    in_valid = 1'b0;
    checkOutput("hold_accepts", accepts, 5);
    for (int k = 0; k < 5; k++) modelStep(0, 0, expYk);
    repeat (10) @(negedge clk150kHz);

    @(negedge clk150kHz);
    banda    = BW'(1);
    uk       = 5000;
    in_valid = 1'b1;
    @(posedge clk150kHz);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk150kHz);
    #1 reset = 1'b0;
    ovCount = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk150kHz);
      #1 if (out_valid === 1'b1) ovCount++;
    end
    checkOutput("midrst_no_valid", ovCount, 0);
    modelReset();
    checkOutput("midrst_yk", yk, 0);
    @(negedge clk150kHz);
    reset = 1'b1;
    applyStimulus(1, 1000, "post_rst");
    checkOutput("post_rst_const", yk, 1000);

    writeCoef(15, 12345);
    applyStimulus(0, 777, "oob_write");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        writeCoef(int'($urandom_range(0, NumBandas * 5 - 1)),
                  longint'($urandom_range(0, 65536)) - 32768);
      if ($urandom_range(0, 7) == 0) clearState();
      b = int'($urandom_range(0, 3));
      u = longint'($urandom_range(0, 4194303)) - 2097152;
      applyStimulus(b, u, "rand");
    end

    writeCoef(0, 8192);
    for (int k = 1; k < 5; k++) writeCoef(k, 0);
    clearState();
    applyStimulus(0, 3, "round_pos");
    applyStimulus(0, -3, "round_neg");
`ifdef FILTRO_REDONDEO_EN
    checkOutput("round_neg_const", yk, -1);
`else
    checkOutput("round_neg_const", yk, -2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/filtro_biquad_multibanda.md
Name: filtro_biquad_multibanda

Overview:
Time-multiplexed biquad IIR engine (direct form II) serving NumBandas independent channels. Each channel has its own run-time-loadable coefficient set and its own two-sample state. One shared multiplier/accumulator is sequenced by an FSM, replacing five parallel multipliers and fixed coefficient muxes. It sits between the sample source and the band outputs in the filter chain, one request per sample per band.

Parameters:
Width, 22, sample/coefficient word width, signed fixed point
Presicion, 14, fractional bits (1.0 = 2^Presicion)
NumBandas, 3, number of independent channels (>=1)
AccGuard, 4, accumulator guard bits above Width

Ports:
clk150kHz  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low; clears all state, coefficients and outputs
in_valid  in  1  request valid
in_ready  out  1  engine can accept a request (IDLE only)
banda  in  BW=max(1,$clog2(NumBandas))  channel for this request
uk  in  Width  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(NumBandas*5)  = band*5+idx; idx 0=b0,1=b1,2=b2,3=a1,4=a2
coef_data  in  Width  signed coefficient
clr_estado  in  1  synchronous clear of all channel states and sat_flag
yk  out  Width  signed filtered output, registered
out_valid  out  1  one-cycle pulse, yk valid
sat_flag  out  1  sticky: any fk or yk saturation since last clear

Behaviour:
- Reset (async, reset=0): FSM->IDLE, in_ready=1, yk=0, out_valid=0, sat_flag=0, all w1/w2=0; coefficients reset to b0=2^Presicion, others 0 (identity filter).
- Equations per channel: fk = sat(uk + a1*w1 + a2*w2); yk = sat(b0*fk + b1*w1 + b2*w2); then w2<=w1, w1<=fk. a-coefficients stored pre-negated (added).
- Products: Width x Width -> 2*Width, arithmetic shift right by Presicion (floor), sign-extended into Width+AccGuard accumulator; sat() clamps to [-2^(Width-1), 2^(Width-1)-1].
- FSM: IDLE -> MA1 -> MA2 -> FK -> MB0 -> MB1 -> MB2 -> DONE -> IDLE. Request captured (uk, banda latched) on in_valid&&in_ready in IDLE. MA1 acc=uk+a1*w1; MA2 acc+=a2*w2; FK fk=sat(acc), acc cleared; MB0/MB1/MB2 accumulate; DONE: yk<=sat(acc), out_valid=1, channel state updated.
- Latency: out_valid asserted 7 cycles after the accept edge; throughput 1 request / 8 cycles. in_ready=0 outside IDLE; in_valid there is ignored (no queueing).
- banda >= NumBandas: accepted, same 7-cycle latency, yk=uk (bypass), no state update, no saturation flagging.
- Coefficient writes accepted in any state; out-of-range coef_addr ignored. Read-before-write: a write in the cycle the coefficient is consumed takes effect on the next use.
- clr_estado: honoured only in IDLE; if asserted together with an accept, clear wins and the request is not accepted (in_ready forced 0 that cycle). Ignored while busy.
- sat_flag set in the cycle fk or yk clamps; held until reset or clr_estado.
- Reset mid-operation: computation abandoned, no out_valid, states and coefficients back to reset values.

Optional Feature:
FILTRO_REDONDEO_EN: when defined, every product adds 2^(Presicion-1) before the shift (round half toward +inf). When undefined, plain floor truncation. No timing or interface change.

Test Plan:
- Reset then band0 uk=1000 -> yk=1000, out_valid exactly 7 cycles after accept, sat_flag=0.
- Band1 b0=8192, a1=8192; impulse uk=16384 then 0,0 -> yk=8192, 4096, 2048.
- Interleave band0 uk=500 and band1 impulse sequence -> band1 outputs identical to previous case; band0 yk=500 each time.
- Band2 b0=32768, uk=1500000 -> yk=2097151, sat_flag=1; uk=-1500000 -> yk=-2097152; clr_estado in IDLE -> sat_flag=0.
- in_valid held high 40 cycles -> exactly 5 accepts, in_ready high 1 cycle in 8; reset asserted in MB0 -> no out_valid, coefficient read of band1 b0 returns 16384 behaviour (identity).
- b0=8192, uk=3 / uk=-3 -> yk=1 / -2 without macro; yk=2 / -1 with FILTRO_REDONDEO_EN.
